// File: rtl/alarm_arm_controller_pkg.sv
// Shared encodings for the alarm arming sequencer: FSM states and tripped-zone codes.
package alarm_arm_controller_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4,
        ST_SILENCED = 3'd5
    } alarm_state_e;

    localparam logic [2:0] TRIP_NONE       = 3'd0;
    localparam logic [2:0] TRIP_ENTRY_DOOR = 3'd1;
    localparam logic [2:0] TRIP_PANIC      = 3'd7;

endpackage

// File: rtl/alarm_arm_controller_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; clr restarts the period.
module alarm_arm_controller_tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/alarm_arm_controller.sv
// Home alarm arming sequencer: exit/entry delays, armed watch, siren timing and zone reporting.
module alarm_arm_controller
    import alarm_arm_controller_pkg::*;
#(
    parameter int unsigned NZONES      = 5,
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned EXIT_TICKS  = 30,
    parameter int unsigned ENTRY_TICKS = 15,
    parameter int unsigned SIREN_TICKS = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NZONES-1:0] opening,
    input  logic              arm_req,
    input  logic              disarm_req,
    input  logic              panic,
    output logic [2:0]        state,
    output logic              siren,
    output logic [7:0]        countdown,
    output logic [2:0]        tripped_zone,
    output logic [NZONES-1:0] zone_latch,
    output logic              arm_fault
);

    if (NZONES < 2 || NZONES > 6) begin : g_bad_nzones
        $error("alarm_arm_controller: NZONES must be 2..6");
    end
    if (TICK_DIV == 0) begin : g_bad_tick_div
        $error("alarm_arm_controller: TICK_DIV must be nonzero");
    end
    if (EXIT_TICKS == 0 || EXIT_TICKS > 255) begin : g_bad_exit
        $error("alarm_arm_controller: EXIT_TICKS must be 1..255");
    end
    if (ENTRY_TICKS == 0 || ENTRY_TICKS > 255) begin : g_bad_entry
        $error("alarm_arm_controller: ENTRY_TICKS must be 1..255");
    end
    if (SIREN_TICKS == 0 || SIREN_TICKS > 255) begin : g_bad_siren
        $error("alarm_arm_controller: SIREN_TICKS must be 1..255");
    end

    // Lowest open instant zone as a 1-based code, TRIP_NONE if none are open.
    function automatic logic [2:0] first_instant(input logic [NZONES-1:0] z);
        logic [2:0] r;
        r = TRIP_NONE;
        for (int i = NZONES - 1; i >= 1; i--) begin
            if (z[i]) r = 3'(i + 1);
        end
        return r;
    endfunction

    alarm_state_e      state_q, state_d;
    logic [7:0]        countdown_d;
    logic [2:0]        trip_d;
    logic [2:0]        instant_code;
    logic              fault_d;
    logic              reload;
    logic              clr_latch;
    logic              tick;
    logic              prescaler_clr;
    logic              watching;

    alarm_arm_controller_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (prescaler_clr),
        .tick (tick)
    );

    assign instant_code  = first_instant(opening);
    assign prescaler_clr = reload || (state_d != state_q);
    assign watching      = (state_q == ST_ARMED) || (state_q == ST_ENTRY) ||
                           (state_q == ST_ALARM) || (state_q == ST_SILENCED);

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown;
        trip_d      = tripped_zone;
        fault_d     = 1'b0;
        reload      = 1'b0;
        clr_latch   = 1'b0;
        if (panic) begin
            state_d     = ST_ALARM;
            countdown_d = 8'(SIREN_TICKS);
            trip_d      = TRIP_PANIC;
            reload      = 1'b1;
        end else if (disarm_req) begin
            // A disarm also swallows any arm_req arriving in the same cycle.
            if (state_q != ST_DISARMED) begin
                state_d     = ST_DISARMED;
                countdown_d = 8'd0;
            end
        end else begin
            unique case (state_q)
                ST_DISARMED: begin
                    if (arm_req) begin
                        if (opening == '0) begin
                            state_d     = ST_EXIT;
                            countdown_d = 8'(EXIT_TICKS);
                            trip_d      = TRIP_NONE;
                            clr_latch   = 1'b1;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end
                end
                ST_EXIT: begin
                    if (tick) begin
                        if (countdown == 8'd1) begin
                            state_d     = ST_ARMED;
                            countdown_d = 8'd0;
                        end else begin
                            countdown_d = countdown - 8'd1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (instant_code != TRIP_NONE) begin
                        state_d     = ST_ALARM;
                        countdown_d = 8'(SIREN_TICKS);
                        trip_d      = instant_code;
                    end else if (opening[0]) begin
                        state_d     = ST_ENTRY;
                        countdown_d = 8'(ENTRY_TICKS);
                        trip_d      = TRIP_ENTRY_DOOR;
                    end
                end
                ST_ENTRY: begin
                    // First trip wins: the entry door code is kept when an instant zone follows.
                    if (instant_code != TRIP_NONE || (tick && countdown == 8'd1)) begin
                        state_d     = ST_ALARM;
                        countdown_d = 8'(SIREN_TICKS);
                    end else if (tick) begin
                        countdown_d = countdown - 8'd1;
                    end
                end
                ST_ALARM: begin
                    if (tick) begin
                        if (countdown == 8'd1) begin
                            state_d     = ST_SILENCED;
                            countdown_d = 8'd0;
                        end else begin
                            countdown_d = countdown - 8'd1;
                        end
                    end
                end
                ST_SILENCED: begin
                end
                default: begin
                    state_d     = ST_DISARMED;
                    countdown_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_DISARMED;
            countdown    <= 8'd0;
            tripped_zone <= TRIP_NONE;
            zone_latch   <= '0;
            siren        <= 1'b0;
            arm_fault    <= 1'b0;
        end else begin
            state_q      <= state_d;
            countdown    <= countdown_d;
            tripped_zone <= trip_d;
            siren        <= (state_d == ST_ALARM);
            arm_fault    <= fault_d;
            if (clr_latch) begin
                zone_latch <= '0;
            end else if (watching) begin
                zone_latch <= zone_latch | opening;
            end
        end
    end

    assign state = state_q;

endmodule
